// File: rtl/pragmatic_seq_ctrl_pkg.sv
// Shared definitions for the pragmatic weight-scheduler sequencing controller.
// State codes stay plain localparam vectors so older netlists can still match them.
package pragmatic_seq_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_FETCH   = 2'd1;
  localparam state_t ST_COMPUTE = 2'd2;
  localparam state_t ST_DRAIN   = 2'd3;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int MAG_W          = DEF_DATA_WIDTH - 1;

  // Sign-magnitude weights: the top bit is the sign, the rest is magnitude.
  function automatic int mag_width(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/pragmatic_seq_ctrl_vec_max_popcount.sv
// Combinational group cycle count: largest magnitude popcount over all lanes.
// Sign bits do not contribute; one offset issues per set magnitude bit.
module vec_max_popcount
  import pragmatic_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_data,
  output logic [CNT_W-1:0]                      npop
);

  localparam int MW = mag_width(DATA_WIDTH);
  localparam int P  = 1 << $clog2(VEC_LENGTH);

  // Heap-ordered max tree: node 0 is the root, leaves sit at P-1 .. 2P-2.
  logic [CNT_W-1:0] node [2*P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < VEC_LENGTH) begin : g_lane
      assign node[P-1+i] = CNT_W'($countones(w_data[i][MW-1:0]));
    end else begin : g_pad
      assign node[P-1+i] = '0;
    end
  end

  for (genvar i = 0; i < P-1; i++) begin : g_max
    assign node[i] = (node[2*i+1] > node[2*i+2]) ? node[2*i+1] : node[2*i+2];
  end

  assign npop = node[0];

endmodule

// File: rtl/pragmatic_seq_ctrl.sv
// Sequencing controller for the one-offset-per-cycle weight scheduler: loads weight
// groups, meters offset-issue cycles per group and tracks tile completion.
module pragmatic_seq_ctrl
  import pragmatic_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8,
  parameter int GRP_W      = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [GRP_W-1:0]                      cfg_num_groups,
  output logic                                  busy,
  output logic                                  tile_done,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_data,
  output logic                                  sched_wen_rf,
  output logic                                  sched_en_comp,
  output logic                                  op_valid,
  output logic                                  op_last,
  input  logic                                  op_ready
);

  state_t           state, state_nxt;
  logic [GRP_W-1:0] grp_left;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] npop;
  logic             w_fire;
  logic             last_issue;
  logic             drain_ok;

  // w_data also feeds the scheduler weight port directly; only its cycle count is needed here.
  vec_max_popcount #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH),
    .CNT_W      (CNT_W)
  ) u_max_pop (
    .w_data (w_data),
    .npop   (npop)
  );

  assign busy          = (state != ST_IDLE);
  assign sched_en_comp = (state == ST_COMPUTE) && (rem != '0) && (!op_valid || op_ready);
  assign last_issue    = sched_en_comp && (rem == CNT_W'(1));
  // Overlap load on the final offset keeps back-to-back groups bubble-free.
  assign w_ready       = (state == ST_FETCH) || (last_issue && (grp_left != '0));
  assign w_fire        = w_valid && w_ready;
  assign sched_wen_rf  = w_fire;
  assign drain_ok      = !op_valid || (op_ready && op_last);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start && (cfg_num_groups != '0)) state_nxt = ST_FETCH;
      end
      ST_FETCH, ST_COMPUTE: begin
        if (w_fire) begin
          if (npop != '0)                    state_nxt = ST_COMPUTE;
          else if (grp_left == GRP_W'(1))    state_nxt = ST_DRAIN;
          else                               state_nxt = ST_FETCH;
        end else if (last_issue) begin
          state_nxt = (grp_left != '0) ? ST_FETCH : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_ok) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      grp_left  <= '0;
      rem       <= '0;
      op_valid  <= 1'b0;
      op_last   <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      tile_done <= ((state == ST_IDLE) && start && (cfg_num_groups == '0)) ||
                   ((state == ST_DRAIN) && drain_ok);

      if ((state == ST_IDLE) && start) grp_left <= cfg_num_groups;
      else if (w_fire)                 grp_left <= grp_left - GRP_W'(1);

      if (w_fire)             rem <= npop;
      else if (sched_en_comp) rem <= rem - CNT_W'(1);

      // Mirrors the scheduler's output register: one cycle behind en_comp, held under stall.
      if (sched_en_comp) begin
        op_valid <= 1'b1;
        op_last  <= (rem == CNT_W'(1));
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pragmatic_seq_ctrl.sv
// Bench for pragmatic_seq_ctrl: directed scenarios plus randomized tiles checked
// against a transaction-level model of group beats and tile completion timing.
module tb_pragmatic_seq_ctrl;

  localparam int DW = 8;
  localparam int VL = 8;
  localparam int GW = 8;
  localparam int TO = 4000;

  logic clk = 1'b0;
  logic reset, start, busy, tile_done, w_valid, w_ready;
  logic [GW-1:0] cfg;
  logic [VL-1:0][DW-1:0] w_data;
  logic wen, en, op_valid, op_last, op_ready;

  always #5 clk = ~clk;

  pragmatic_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .GRP_W(GW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_num_groups (cfg),
    .busy           (busy),
    .tile_done      (tile_done),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_data         (w_data),
    .sched_wen_rf   (wen),
    .sched_en_comp  (en),
    .op_valid       (op_valid),
    .op_last        (op_last),
    .op_ready       (op_ready)
  );

  int n_chk, n_fail, cyc, tot_exp, busy_low;
  int b_wen, b_en, b_beat, b_done, b_tot;
  int q_wen[$], q_en[$], q_beat[$], q_done[$];
  bit q_last[$];
  bit exp_q[$];
  bit w_fired, beat_fired, tile_act, in_stall;
  logic [VL-1:0][DW-1:0] vecs [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Offsets per group = the largest count of set magnitude bits in any lane.
  function automatic int ref_npop(input logic [VL-1:0][DW-1:0] v);
    int m, c;
    m = 0;
    for (int j = 0; j < VL; j++) begin
      c = 0;
      for (int b = 0; b < DW-1; b++) c += int'(v[j][b]);
      if (c > m) m = c;
    end
    return m;
  endfunction

  function automatic logic [VL-1:0][DW-1:0] rand_vec();
    logic [VL-1:0][DW-1:0] v;
    bit s;
    for (int j = 0; j < VL; j++) begin
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        v[j] = '0;
        v[j][DW-1] = s;
      end else begin
        v[j] = DW'($urandom);
      end
    end
    if ($urandom_range(0, 5) == 0) v = '0;
    return v;
  endfunction

  function automatic logic [7:0] lasts(input int base, input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[6:0], q_last[base+i]};
    return r;
  endfunction

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    int n;
    @(negedge clk);
    w_fired = 1'b0;
    beat_fired = 1'b0;
    if (!reset) begin
      if (wen) begin
        chk("wen_needs_valid", w_valid, 1);
        q_wen.push_back(cyc);
        w_fired = 1'b1;
        n = ref_npop(w_data);
        tot_exp += n;
        for (int k = 0; k < n; k++) exp_q.push_back(k == n-1);
      end
      if (en) begin
        q_en.push_back(cyc);
        chk("en_while_stalled", !op_valid || op_ready, 1);
      end
      if (in_stall) chk("stall_hold", {en, op_valid, op_last}, 3'b010);
      if (op_valid && op_ready) begin
        beat_fired = 1'b1;
        q_beat.push_back(cyc);
        q_last.push_back(op_last);
        if (exp_q.size() == 0) chk("beat_unexpected", exp_q.size(), 1);
        else                   chk("op_last", op_last, exp_q.pop_front());
      end
      if (tile_done) q_done.push_back(cyc);
      if (tile_act && !busy && busy_low < 0) busy_low = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_tile(input int cfgv, input bit rnd, input int stall_len, input bit poke);
    int k, stall, t0, to, lastw, lastb, exp_done;
    bit stalled, poked;
    b_wen = q_wen.size(); b_en = q_en.size(); b_beat = q_beat.size();
    b_done = q_done.size(); b_tot = tot_exp;
    k = 0; stall = 0; stalled = 0; poked = 0; to = 0;
    start = 1'b1;
    cfg = GW'(cfgv);
    if (rnd) begin
      w_data = rand_vec();
      w_valid = ($urandom_range(0, 3) != 0);
      op_ready = ($urandom_range(0, 3) != 0);
    end else begin
      w_data = vecs[0];
      w_valid = (cfgv != 0);
      op_ready = 1'b1;
    end
    t0 = cyc;
    busy_low = -1;
    tick();
    start = 1'b0;
    tile_act = 1'b1;
    while (q_done.size() == b_done && to < TO) begin
      if (rnd) begin
        if (w_fired || !w_valid) begin
          w_valid = ($urandom_range(0, 3) != 0);
          w_data = rand_vec();
        end
      end else if (w_fired) begin
        k++;
        if (k < cfgv) w_data = vecs[k];
        else          w_valid = 1'b0;
      end
      if (beat_fired && stall_len > 0 && !stalled) begin
        stall = stall_len;
        stalled = 1'b1;
      end
      if (stall > 0) begin
        op_ready = 1'b0;
        in_stall = 1'b1;
        stall--;
      end else begin
        in_stall = 1'b0;
        op_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (poke && !poked && (q_en.size() - b_en) >= 2) begin
        start = 1'b1;
        cfg = GW'(5);
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      to++;
    end
    in_stall = 1'b0;
    start = 1'b0;
    chk("done_count", q_done.size() - b_done, 1);
    chk("wen_count", q_wen.size() - b_wen, cfgv);
    chk("beats_pending", exp_q.size(), 0);
    chk("beat_total", q_beat.size() - b_beat, tot_exp - b_tot);
    chk("en_total", q_en.size() - b_en, tot_exp - b_tot);
    // Done follows both the final load's drain step and the final beat by one cycle.
    if (cfgv == 0 || q_wen.size() == b_wen) begin
      exp_done = t0 + 1;
    end else begin
      lastw = q_wen[q_wen.size()-1];
      lastb = (q_beat.size() > b_beat) ? q_beat[q_beat.size()-1] : -1;
      exp_done = ((lastw + 1 > lastb) ? lastw + 1 : lastb) + 1;
    end
    if (q_done.size() > b_done) chk("done_cycle", q_done[b_done], exp_done);
    chk("busy_low_cycle", busy_low, exp_done);
    tile_act = 1'b0;
    tick();
    chk("done_single_pulse", {tile_done, busy}, 2'b00);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; tot_exp = 0; busy_low = -1;
    tile_act = 1'b0; in_stall = 1'b0;
    reset = 1'b1; start = 1'b0; cfg = '0; w_valid = 1'b0; w_data = '0; op_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_state", {busy, tile_done, w_ready, wen, en, op_valid, op_last}, 7'd0);

    // Single group, npop=3, no stall.
    for (int j = 0; j < VL; j++) vecs[0][j] = 8'h01;
    vecs[0][0] = 8'h07;
    run_tile(1, 0, 0, 0);
    chk("t1_en_count", q_en.size() - b_en, 3);
    chk("t1_en_span", q_en[b_en+2] - q_en[b_en], 2);
    chk("t1_en_after_wen", q_en[b_en] - q_wen[b_wen], 1);
    chk("t1_lasts", lasts(b_beat, 3), 8'b001);

    // Back-to-back groups with overlap load.
    vecs[0] = '0; vecs[0][0] = 8'h03;
    vecs[1] = '0; vecs[1][0] = 8'h40;
    run_tile(2, 0, 0, 0);
    chk("t2_en_count", q_en.size() - b_en, 3);
    chk("t2_en_span", q_en[b_en+2] - q_en[b_en], 2);
    chk("t2_overlap", q_wen[b_wen+1], q_en[b_en+1]);
    chk("t2_lasts", lasts(b_beat, 3), 8'b011);

    // Empty (sign-only) group followed by a one-beat group.
    for (int j = 0; j < VL; j++) vecs[0][j] = 8'h80;
    vecs[1] = '0; vecs[1][2] = 8'h01;
    run_tile(2, 0, 0, 0);
    chk("t3_en_count", q_en.size() - b_en, 1);
    chk("t3_en_after_g1", q_en[b_en] - q_wen[b_wen+1], 1);
    chk("t3_lasts", lasts(b_beat, 1), 8'b1);

    // Backpressure for 4 cycles after the first beat.
    vecs[0] = '0; vecs[0][5] = 8'h0F;
    run_tile(1, 0, 4, 0);
    chk("t4_beats", q_beat.size() - b_beat, 4);
    chk("t4_stall_gap", q_beat[b_beat+1] - q_beat[b_beat], 5);
    chk("t4_lasts", lasts(b_beat, 4), 8'b0001);

    // Reset in COMPUTE, then a zero-group tile.
    b_en = q_en.size();
    w_data = '0; w_data[0] = 8'h7F;
    start = 1'b1; cfg = GW'(1); w_valid = 1'b1; op_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && q_en.size() == b_en; i++) tick();
    chk("t5_in_compute", q_en.size() > b_en, 1);
    reset = 1'b1; w_valid = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("t5_reset_outputs", {busy, tile_done, w_ready, wen, en, op_valid, op_last}, 7'd0);
    run_tile(0, 0, 0, 0);

    // Max popcount with a start pulse during the group.
    vecs[0] = '0; vecs[0][3] = 8'hFF;
    run_tile(1, 0, 0, 1);
    chk("t6_en_count", q_en.size() - b_en, 7);
    chk("t6_en_span", q_en[b_en+6] - q_en[b_en], 6);

    // Randomized tiles.
    for (int t = 0; t < 40; t++) begin
      run_tile(int'($urandom_range(0, 4)), 1, 0, 0);
      w_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
